// File: rtl/bcd_pkg.sv
// Shared types and helpers for the digit-serial BCD add/subtract unit.
// Holds the FSM state type, digit width and nines-complement helper.
package bcd_pkg;

  localparam int DW = 4;

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    INC,
    CMPL,
    DONE
  } state_t;

  // Out-of-range digits 10..15 fold onto 9..4
  function automatic logic [DW-1:0] nines(input logic [DW-1:0] d);
    logic [DW:0] t;
    if (d > 4'd9) t = 5'd19 - {1'b0, d};
    else          t = 5'd9 - {1'b0, d};
    return t[DW-1:0];
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Single BCD digit adder with decimal adjust.
// Shared by the serial add and end-around increment passes.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          cin,
  output logic [DW-1:0] s,
  output logic          cout
);

  logic [DW:0] sum;
  logic [DW:0] adj;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
    adj  = sum + 5'd6;
    cout = sum > 5'd9;
    s    = cout ? adj[DW-1:0] : sum[DW-1:0];
  end

endmodule

// File: rtl/bcd_addsub_seq.sv
// Digit-serial signed BCD add/subtract with valid/ready handshakes.
// Subtract uses nines complement plus end-around carry or recomplement.
module bcd_addsub_seq
  import bcd_pkg::*;
#(
  parameter int N = 25
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            op,
  input  logic            a_sign,
  input  logic            b_sign,
  input  logic [N*DW-1:0] a_mag,
  input  logic [N*DW-1:0] b_mag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_sign,
  output logic [N*DW-1:0] out_mag,
  output logic            out_ovf,
  output logic            out_zero,
  output logic            out_err
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t          state, nxt;
  logic [N*DW-1:0] a_r, b_r, res, res_n;
  logic            as_r, sub_r, carry;
  logic [IW-1:0]   idx;

  logic [DW-1:0]   da, db, dsum;
  logic            dco, last;
  logic            fin_ovf, fin_sign, fin_zero, err_n;

  assign in_ready = (state == IDLE);

  bcd_digit_adder u_dig (
    .a    (da),
    .b    (db),
    .cin  (carry),
    .s    (dsum),
    .cout (dco)
  );

  always_comb begin
    last = (idx == LAST);
    da   = res[int'(idx)*DW +: DW];
    db   = '0;
    if (state == ADD) begin
      da = a_r[int'(idx)*DW +: DW];
      db = sub_r ? nines(b_r[int'(idx)*DW +: DW])
                 : b_r[int'(idx)*DW +: DW];
    end
  end

  always_comb begin
    nxt   = state;
    res_n = res;
    unique case (state)
      IDLE: if (in_valid) nxt = ADD;
      ADD: begin
        res_n[int'(idx)*DW +: DW] = dsum;
        if (last) nxt = !sub_r ? DONE : (dco ? INC : CMPL);
      end
      INC: begin
        res_n[int'(idx)*DW +: DW] = dsum;
        if (last) nxt = DONE;
      end
      CMPL: begin
        for (int i = 0; i < N; i++)
          res_n[i*DW +: DW] = nines(res[i*DW +: DW]);
        nxt = DONE;
      end
      DONE: if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    fin_ovf  = (state == ADD) && !sub_r && dco;
    fin_zero = (res_n == '0);
    fin_sign = (state == CMPL) ? ~as_r : as_r;
    fin_sign = fin_sign & ~(fin_zero & ~fin_ovf);
    err_n    = 1'b0;
    for (int i = 0; i < N; i++)
      if (a_r[i*DW +: DW] > 4'd9 || b_r[i*DW +: DW] > 4'd9)
        err_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      res       <= '0;
      as_r      <= 1'b0;
      sub_r     <= 1'b0;
      carry     <= 1'b0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_mag   <= '0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      state <= nxt;
      unique case (state)
        IDLE: if (in_valid) begin
          a_r   <= a_mag;
          b_r   <= b_mag;
          as_r  <= a_sign;
          sub_r <= a_sign ^ b_sign ^ op;
          carry <= 1'b0;
          idx   <= '0;
        end
        ADD, INC: begin
          res   <= res_n;
          carry <= dco;
          idx   <= last ? '0 : idx + 1'b1;
        end
        CMPL: res <= res_n;
        default: ;
      endcase
      if (nxt == DONE && state != DONE) begin
        out_valid <= 1'b1;
        out_mag   <= res_n;
        out_sign  <= fin_sign;
        out_ovf   <= fin_ovf;
        out_zero  <= fin_zero;
        out_err   <= err_n;
      end else if (state == DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
